// File: rtl/echo_ranger_pkg.sv
// Shared types and constants for the echo_ranger ultrasonic ranging controller.
// Holds the FSM state encoding and the width of the trigger/timeout timer.
package echo_ranger_pkg;

  localparam int RANGER_TMR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE
  } ranger_state_t;

endpackage

// File: rtl/echo_ranger_sync.sv
// Two-flop synchronizer (module echo_sync) bringing the asynchronous ECHO line into
// the CLKOUT domain; instantiated by echo_ranger only when ECHO_RANGER_SYNC_EN is defined.
module echo_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/echo_ranger.sv
// Ultrasonic ranging controller: fires a TRIG_CYC-cycle trigger, then times the ECHO pulse.
// Build option ECHO_RANGER_SYNC_EN adds a two-flop synchronizer on ECHO (+2 cycles echo latency).
module echo_ranger
  import echo_ranger_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter int unsigned TRIG_CYC = 10,
  parameter int unsigned TIMEOUT  = 50000
) (
  input  logic             CLKOUT,
  input  logic             reset,
  input  logic             start,
  input  logic             ECHO,
  output logic             pulse,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             timeout,
  output logic             sat,
  output ranger_state_t    o_dbg_state
);

  localparam logic [RANGER_TMR_W-1:0] TRIG_LAST = RANGER_TMR_W'(TRIG_CYC - 1);
  localparam logic [RANGER_TMR_W-1:0] TMO_LAST  = RANGER_TMR_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]        CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]        CNT_PRE   = CNT_MAX - CNT_W'(1);

  logic w_e;

`ifdef ECHO_RANGER_SYNC_EN
  echo_sync u_echo_sync (
    .i_clk   (CLKOUT),
    .i_reset (reset),
    .i_d     (ECHO),
    .o_q     (w_e)
  );
`else
  assign w_e = ECHO;
`endif

  ranger_state_t             r_state;
  ranger_state_t             w_state_nxt;
  logic [RANGER_TMR_W-1:0]   r_tmr;
  logic [RANGER_TMR_W-1:0]   w_tmr_nxt;
  logic [CNT_W-1:0]          r_count;
  logic [CNT_W-1:0]          w_count_nxt;
  logic                      r_timeout;
  logic                      w_timeout_nxt;
  logic                      r_sat;
  logic                      w_sat_nxt;

  always_ff @(posedge CLKOUT) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tmr     <= '0;
      r_count   <= '0;
      r_timeout <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_count   <= w_count_nxt;
      r_timeout <= w_timeout_nxt;
      r_sat     <= w_sat_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_nxt     = r_tmr;
    w_count_nxt   = r_count;
    w_timeout_nxt = r_timeout;
    w_sat_nxt     = r_sat;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt   = TRIG;
          w_tmr_nxt     = '0;
          w_count_nxt   = '0;
          w_timeout_nxt = 1'b0;
          w_sat_nxt     = 1'b0;
        end
      end
      TRIG: begin
        if (r_tmr == TRIG_LAST) begin
          w_state_nxt = WAIT_RISE;
          w_tmr_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr + RANGER_TMR_W'(1);
        end
      end
      WAIT_RISE: begin
        // Timer runs 0..TIMEOUT, so a timeout strobes valid TIMEOUT+1 cycles after entry.
        if (w_e) begin
          w_state_nxt = MEASURE;
          w_count_nxt = CNT_W'(1);
        end else if (r_tmr == TMO_LAST) begin
          w_state_nxt   = DONE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr + RANGER_TMR_W'(1);
        end
      end
      MEASURE: begin
        if (!w_e) begin
          w_state_nxt = DONE;
        end else if (r_count == CNT_PRE) begin
          w_count_nxt = CNT_MAX;
          w_sat_nxt   = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_count_nxt = r_count + CNT_W'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign pulse       = (r_state == TRIG);
  assign busy        = (r_state != IDLE);
  assign valid       = (r_state == DONE);
  assign count       = r_count;
  assign timeout     = r_timeout;
  assign sat         = r_sat;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_echo_ranger.sv
// Self-checking bench for echo_ranger: randomized echo windows scored against a
// behavioural model, with a 16-bit instance and an 8-bit instance for saturation.
`timescale 1ns/1ps
module tb_echo_ranger;
  import echo_ranger_pkg::*;

  localparam int TRIG_CYC = 10;
  localparam int TIMEOUT  = 100;
`ifdef ECHO_RANGER_SYNC_EN
  localparam int E_LAT = 2;
`else
  localparam int E_LAT = 0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start16 = 1'b0, echo16 = 1'b0;
  logic          pulse16, busy16, valid16, timeout16, sat16;
  logic [15:0]   count16;
  ranger_state_t st16;

  logic          start8 = 1'b0, echo8 = 1'b0;
  logic          pulse8, busy8, valid8, timeout8, sat8;
  logic [7:0]    count8;
  ranger_state_t st8;

  echo_ranger #(.CNT_W(16), .TRIG_CYC(TRIG_CYC), .TIMEOUT(TIMEOUT)) u_dut16 (
    .CLKOUT(clk), .reset(reset), .start(start16), .ECHO(echo16),
    .pulse(pulse16), .busy(busy16), .count(count16), .valid(valid16),
    .timeout(timeout16), .sat(sat16), .o_dbg_state(st16)
  );

  echo_ranger #(.CNT_W(8), .TRIG_CYC(TRIG_CYC), .TIMEOUT(TIMEOUT)) u_dut8 (
    .CLKOUT(clk), .reset(reset), .start(start8), .ECHO(echo8),
    .pulse(pulse8), .busy(busy8), .count(count8), .valid(valid8),
    .timeout(timeout8), .sat(sat8), .o_dbg_state(st8)
  );

  bit            cur8 = 1'b0;
  logic          w_pulse, w_busy, w_valid;
  logic [15:0]   w_count;
  ranger_state_t w_state;
  assign w_pulse = cur8 ? pulse8 : pulse16;
  assign w_busy  = cur8 ? busy8  : busy16;
  assign w_valid = cur8 ? valid8 : valid16;
  assign w_count = cur8 ? {8'h00, count8} : count16;
  assign w_state = cur8 ? st8 : st16;

  int n_checks = 0;
  int n_errors = 0;

  logic [17:0] exp_q16[$];
  logic [9:0]  exp_q8[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: what a measurement of an echo window (d cycles after
  // WAIT_RISE entry, n cycles wide; n=0 means no echo) must report, and when
  function automatic void model(input int d, input int n, input int cw,
                                output logic tmo, output logic sat_o,
                                output int cnt, output int vidx);
    int mx;
    mx    = (1 << cw) - 1;
    tmo   = 1'b0;
    sat_o = 1'b0;
    if (n == 0 || d + E_LAT > TIMEOUT) begin
      tmo  = 1'b1;
      cnt  = 0;
      vidx = TIMEOUT + 1;
    end else if (n >= mx) begin
      sat_o = 1'b1;
      cnt   = mx;
      vidx  = d + E_LAT + mx;
    end else begin
      cnt  = n;
      vidx = d + E_LAT + n + 1;
    end
  endfunction

  // driver tasks
  task automatic drive_echo(input bit sel8, input logic v);
    if (sel8) echo8 = v; else echo16 = v;
  endtask

  task automatic drive_start(input bit sel8, input logic v);
    if (sel8) start8 = v; else start16 = v;
  endtask

  // Called at a negedge; busy_at / rst_at are offsets from echo rise (-1 = unused).
  task automatic run_meas(input bit sel8, input int d, input int n,
                          input int busy_at, input int rst_at);
    logic tmo, sat_o;
    int   cnt, vidx, plen;
    bit   got, aborted;
    cur8 = sel8;
    model(d, n, sel8 ? 8 : 16, tmo, sat_o, cnt, vidx);
    if (rst_at < 0) begin
      if (sel8) exp_q8.push_back({tmo, sat_o, 8'(cnt)});
      else      exp_q16.push_back({tmo, sat_o, 16'(cnt)});
    end
    drive_start(sel8, 1'b1);
    @(negedge clk);
    drive_start(sel8, 1'b0);
    plen = 0;
    while (w_pulse && plen < TRIG_CYC + 5) begin
      plen++;
      @(negedge clk);
    end
    check("pulse_len", 64'(plen), 64'(TRIG_CYC));
    got     = 1'b0;
    aborted = 1'b0;
    for (int k = 0; k <= TIMEOUT + n + 50; k++) begin
      if (w_valid) begin
        check("valid_latency", 64'(k), 64'(vidx));
        got = 1'b1;
        break;
      end
      if (rst_at >= 0 && k == d + rst_at) begin
        drive_echo(sel8, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_outputs", {w_pulse, w_busy, w_valid, w_count}, 64'd0);
        check("abort_state", 64'(w_state), 64'(IDLE));
        aborted = 1'b1;
        break;
      end
      drive_echo(sel8, (k >= d && k < d + n));
      drive_start(sel8, (busy_at >= 0 && k == d + busy_at));
      @(negedge clk);
    end
    drive_start(sel8, 1'b0);
    if (!aborted) begin
      check("valid_seen", 64'(got), 64'd1);
      if (got) begin
        @(negedge clk);
        drive_echo(sel8, 1'b0);
        check("valid_one_cycle", 64'(w_valid), 64'd0);
        check("idle_after_done", 64'(w_busy), 64'd0);
        check("count_hold", 64'(w_count), 64'(cnt));
      end
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (!reset && valid16) begin
      if (exp_q16.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb16 unexpected valid got=%0h expected=none", {timeout16, sat16, count16});
      end else begin
        check("sb16_result", {timeout16, sat16, count16}, exp_q16.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && valid8) begin
      if (exp_q8.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb8 unexpected valid got=%0h expected=none", {timeout8, sat8, count8});
      end else begin
        check("sb8_result", {timeout8, sat8, count8}, exp_q8.pop_front());
      end
    end
  end

  initial begin
    int d, n;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_out16", {pulse16, busy16, valid16, timeout16, sat16, count16}, 64'd0);
      check("reset_out8", {pulse8, busy8, valid8, timeout8, sat8, count8}, 64'd0);
      echo16 = ~echo16;
      echo8  = ~echo8;
    end
    check("reset_state16", 64'(st16), 64'(IDLE));
    echo16 = 1'b0;
    echo8  = 1'b0;
    reset  = 1'b0;

    run_meas(1'b0, 5, 37, -1, -1);
    run_meas(1'b0, 0, 0, -1, -1);
    run_meas(1'b0, 0, 1, -1, -1);
    run_meas(1'b0, 3, 50, 10, -1);
    run_meas(1'b0, 3, 60, -1, 20);
    run_meas(1'b0, 4, 12, -1, -1);

    run_meas(1'b1, 2, 254, -1, -1);
    run_meas(1'b1, 2, 255, -1, -1);
    run_meas(1'b1, 2, 256, -1, -1);
    run_meas(1'b1, 0, 400, -1, -1);

    for (int i = 0; i < 10; i++) begin
      d = int'($urandom_range(0, 40));
      n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 200));
      run_meas(1'b0, d, n, -1, -1);
    end
    for (int i = 0; i < 4; i++) begin
      d = int'($urandom_range(0, 20));
      n = int'($urandom_range(200, 400));
      run_meas(1'b1, d, n, -1, -1);
    end

    repeat (5) @(negedge clk);
    check("sb16_drained", 64'(exp_q16.size()), 64'd0);
    check("sb8_drained", 64'(exp_q8.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
